// File: rtl/acq_pulse_sequencer_pkg.sv
// Shared types and constants for the acquisition pulse sequencer.
package acq_pulse_sequencer_pkg;

  localparam int unsigned CMD_W         = 16;
  localparam int unsigned FAULT_W       = 2;
  localparam int unsigned CMD_START_BIT = 0;
  localparam int unsigned CMD_ABORT_BIT = 1;
  localparam int unsigned FAULT_TMO     = 0;
  localparam int unsigned FAULT_TRIG    = 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ISSUE,
    WAIT,
    PULSE_END
  } seq_state_e;

endpackage

// File: rtl/acq_timeout_cnt.sv
// Watchdog counter: expire_c fires on the LIMIT-th consecutive enabled cycle since clear.
module acq_timeout_cnt #(
  parameter int unsigned LIMIT = 8192
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  assign expire_c = en && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expire_c) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/acq_pulse_sequencer.sv
// Acquisition controller: arms the trigger, issues one range-bin start per gate per pulse,
// and closes the accumulation group after the configured number of pulses.
module acq_pulse_sequencer
  import acq_pulse_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RB_TIMEOUT = 8192,
  parameter int unsigned CMD_START  = CMD_START_BIT,
  parameter int unsigned CMD_ABORT  = CMD_ABORT_BIT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [CMD_W-1:0]   cmd_i,
  input  logic [CNT_W-1:0]   n_range_bins_i,
  input  logic [CNT_W-1:0]   n_acc_pulses_i,
  input  logic               trig_ready_i,
  input  logic               trig_start_i,
  input  logic               rb_done_i,
  output logic               capture_en_o,
  output logic               trig_arm_o,
  output logic               rb_start_o,
  output logic [CNT_W-1:0]   rb_index_o,
  output logic [CNT_W-1:0]   pulse_count_o,
  output logic               is_first_pls_o,
  output logic               group_done_o,
  output logic [FAULT_W-1:0] fault_o
);

  seq_state_e       state;
  logic             start_q;
  logic [CNT_W-1:0] nbins_q;
  logic [CNT_W-1:0] npulses_q;

  logic abort_c;
  logic start_edge_c;
  logic last_bin_c;
  logic last_pulse_c;
  logic trig_busy_c;
  logic tmo_clear_c;
  logic tmo_en_c;
  logic tmo_expire_c;
  logic cmd_unused_c;

  assign abort_c      = cmd_i[CMD_ABORT];
  assign start_edge_c = cmd_i[CMD_START] && !start_q && !abort_c;
  assign last_bin_c   = (rb_index_o == nbins_q - CNT_W'(1));
  assign last_pulse_c = ((pulse_count_o + CNT_W'(1)) == npulses_q);
  assign trig_busy_c  = trig_start_i && (state == ISSUE || state == WAIT || state == PULSE_END);
  assign cmd_unused_c = ^cmd_i;

  // Watchdog runs only while a bin is outstanding; any other state rearms it.
  assign tmo_clear_c = (state != WAIT);
  assign tmo_en_c    = (state == WAIT) && !rb_done_i && !abort_c;

  acq_timeout_cnt #(
    .LIMIT(RB_TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (tmo_clear_c),
    .en      (tmo_en_c),
    .expire_c(tmo_expire_c)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      start_q        <= 1'b0;
      nbins_q        <= '0;
      npulses_q      <= '0;
      capture_en_o   <= 1'b0;
      trig_arm_o     <= 1'b0;
      rb_start_o     <= 1'b0;
      rb_index_o     <= '0;
      pulse_count_o  <= '0;
      is_first_pls_o <= 1'b0;
      group_done_o   <= 1'b0;
      fault_o        <= '0;
    end else begin
      start_q      <= cmd_i[CMD_START];
      rb_start_o   <= 1'b0;
      group_done_o <= 1'b0;

      // A trigger while a pulse is in flight is dropped but remembered.
      if (trig_busy_c && !abort_c) begin
        fault_o[FAULT_TRIG] <= 1'b1;
      end

      if (state != IDLE && abort_c) begin
        state          <= IDLE;
        capture_en_o   <= 1'b0;
        trig_arm_o     <= 1'b0;
        is_first_pls_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge_c) begin
              state          <= ARM;
              capture_en_o   <= 1'b1;
              trig_arm_o     <= 1'b1;
              is_first_pls_o <= 1'b1;
              fault_o        <= '0;
              pulse_count_o  <= '0;
              rb_index_o     <= '0;
              nbins_q        <= (n_range_bins_i == '0) ? CNT_W'(1) : n_range_bins_i;
              npulses_q      <= (n_acc_pulses_i == '0) ? CNT_W'(1) : n_acc_pulses_i;
            end
          end
          ARM: begin
            if (trig_start_i && trig_ready_i) begin
              state      <= ISSUE;
              trig_arm_o <= 1'b0;
              rb_start_o <= 1'b1;
              rb_index_o <= '0;
            end
          end
          ISSUE: begin
            state <= WAIT;
          end
          WAIT: begin
            if (rb_done_i) begin
              if (last_bin_c) begin
                state <= PULSE_END;
              end else begin
                state      <= ISSUE;
                rb_start_o <= 1'b1;
                rb_index_o <= rb_index_o + CNT_W'(1);
              end
            end else if (tmo_expire_c) begin
              state              <= IDLE;
              fault_o[FAULT_TMO] <= 1'b1;
              capture_en_o       <= 1'b0;
              is_first_pls_o     <= 1'b0;
            end
          end
          PULSE_END: begin
            pulse_count_o  <= pulse_count_o + CNT_W'(1);
            is_first_pls_o <= 1'b0;
            if (last_pulse_c) begin
              state        <= IDLE;
              group_done_o <= 1'b1;
              capture_en_o <= 1'b0;
            end else begin
              state      <= ARM;
              trig_arm_o <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_pulse_sequencer.sv
// Directed bench for acq_pulse_sequencer: group sequencing, config clamping, faults, abort, reset.
module tb_acq_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic [15:0] n_range_bins;
  logic [15:0] n_acc_pulses;
  logic        trig_ready;
  logic        trig_start;
  logic        rb_done;
  logic        capture_en;
  logic        trig_arm;
  logic        rb_start;
  logic [15:0] rb_index;
  logic [15:0] pulse_count;
  logic        is_first;
  logic        group_done;
  logic [1:0]  fault;

  int checks = 0;
  int passes = 0;
  int starts = 0;
  int gdones = 0;
  int s0;
  int g0;
  int n;

  acq_pulse_sequencer #(
    .CNT_W     (16),
    .RB_TIMEOUT(64)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_i         (cmd),
    .n_range_bins_i(n_range_bins),
    .n_acc_pulses_i(n_acc_pulses),
    .trig_ready_i  (trig_ready),
    .trig_start_i  (trig_start),
    .rb_done_i     (rb_done),
    .capture_en_o  (capture_en),
    .trig_arm_o    (trig_arm),
    .rb_start_o    (rb_start),
    .rb_index_o    (rb_index),
    .pulse_count_o (pulse_count),
    .is_first_pls_o(is_first),
    .group_done_o  (group_done),
    .fault_o       (fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rb_start) starts++;
    if (group_done) gdones++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_start(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (rb_start) ok = 1'b1;
      else step();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic trigger();
    trig_start = 1'b1;
    step();
    trig_start = 1'b0;
  endtask

  task automatic start_group(input logic [15:0] nb, input logic [15:0] np);
    cmd = 16'h0000;
    step();
    n_range_bins = nb;
    n_acc_pulses = np;
    cmd = 16'h0001;
    step();
  endtask

  // One pulse: trigger, then answer each bin start with rb_done 20 cycles later.
  task automatic run_pulse(input int nb, input bit first, input bit inj);
    trigger();
    for (int b = 0; b < nb; b++) begin
      wait_start("bin_start");
      chk("rb_index", 32'(rb_index), 32'(b));
      chk("is_first", 32'(is_first), 32'(first));
      if (inj && b == 0) begin
        repeat (5) step();
        trig_start = 1'b1;
        step();
        trig_start = 1'b0;
        repeat (13) step();
      end else begin
        repeat (19) step();
      end
      rb_done = 1'b1;
      step();
      rb_done = 1'b0;
    end
    step();
  endtask

  initial begin
    rst          = 1'b1;
    cmd          = 16'h0000;
    n_range_bins = 16'd0;
    n_acc_pulses = 16'd0;
    trig_ready   = 1'b0;
    trig_start   = 1'b0;
    rb_done      = 1'b0;
    repeat (3) step();
    chk("reset_flags", 32'({capture_en, trig_arm, rb_start, is_first, group_done, fault}), 32'd0);
    chk("reset_counts", 32'({rb_index, pulse_count}), 32'd0);
    rst = 1'b0;
    step();

    // Basic group 3 bins x 2 pulses; bin count changed after start must not matter.
    s0 = starts;
    g0 = gdones;
    start_group(16'd3, 16'd2);
    chk("arm_capture", 32'(capture_en), 32'd1);
    chk("arm_trig_arm", 32'(trig_arm), 32'd1);
    chk("arm_is_first", 32'(is_first), 32'd1);
    n_range_bins = 16'd5;
    trig_start = 1'b1;
    step();
    trig_start = 1'b0;
    repeat (3) step();
    chk("unready_no_start", 32'(starts - s0), 32'd0);
    chk("unready_no_fault", 32'(fault), 32'd0);
    chk("unready_still_arm", 32'(trig_arm), 32'd1);
    trig_ready = 1'b1;
    run_pulse(3, 1'b1, 1'b0);
    chk("p0_count", 32'(pulse_count), 32'd1);
    chk("p0_rearm", 32'(trig_arm), 32'd1);
    chk("p0_no_done", 32'(group_done), 32'd0);
    chk("p0_first_fell", 32'(is_first), 32'd0);
    run_pulse(3, 1'b0, 1'b0);
    chk("g1_done", 32'(group_done), 32'd1);
    chk("g1_count", 32'(pulse_count), 32'd2);
    chk("g1_capture_off", 32'(capture_en), 32'd0);
    step();
    chk("g1_done_pulse", 32'(group_done), 32'd0);
    chk("g1_starts", 32'(starts - s0), 32'd6);
    chk("g1_done_count", 32'(gdones - g0), 32'd1);

    // Zero config behaves as one bin, one pulse.
    s0 = starts;
    g0 = gdones;
    start_group(16'd0, 16'd0);
    run_pulse(1, 1'b1, 1'b0);
    chk("zero_done", 32'(group_done), 32'd1);
    chk("zero_count", 32'(pulse_count), 32'd1);
    step();
    chk("zero_starts", 32'(starts - s0), 32'd1);
    chk("zero_done_count", 32'(gdones - g0), 32'd1);

    // Trigger while waiting on a bin: fault[1], sequence unaffected.
    s0 = starts;
    start_group(16'd2, 16'd1);
    run_pulse(2, 1'b1, 1'b1);
    chk("busy_fault", 32'(fault), 32'd2);
    chk("busy_done", 32'(group_done), 32'd1);
    step();
    chk("busy_starts", 32'(starts - s0), 32'd2);

    // Watchdog: withhold rb_done.
    start_group(16'd1, 16'd1);
    chk("fault_cleared", 32'(fault), 32'd0);
    trigger();
    wait_start("tmo_start");
    n = 0;
    while (!fault[0] && n < 200) begin
      step();
      n++;
    end
    chk("tmo_window", 32'(n >= 64 && n <= 66), 32'd1);
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_capture_off", 32'(capture_en), 32'd0);
    chk("tmo_not_armed", 32'(trig_arm), 32'd0);
    s0 = starts;
    trig_start = 1'b1;
    step();
    trig_start = 1'b0;
    repeat (2) step();
    chk("tmo_idle", 32'(starts - s0), 32'd0);

    // Abort in the same cycle as the last rb_done.
    g0 = gdones;
    start_group(16'd2, 16'd1);
    trigger();
    wait_start("abort_b0");
    repeat (19) step();
    rb_done = 1'b1;
    step();
    rb_done = 1'b0;
    wait_start("abort_b1");
    chk("abort_b1_index", 32'(rb_index), 32'd1);
    repeat (19) step();
    rb_done = 1'b1;
    cmd = 16'h0003;
    step();
    rb_done = 1'b0;
    chk("abort_capture_off", 32'(capture_en), 32'd0);
    chk("abort_no_done", 32'(group_done), 32'd0);
    step();
    chk("abort_no_done_later", 32'(group_done), 32'd0);
    chk("abort_done_count", 32'(gdones - g0), 32'd0);
    chk("abort_count", 32'(pulse_count), 32'd0);
    cmd = 16'h0000;

    // Async reset in the middle of bin 1 with a fault pending.
    start_group(16'd3, 16'd1);
    trigger();
    wait_start("rst_b0");
    repeat (19) step();
    rb_done = 1'b1;
    step();
    rb_done = 1'b0;
    wait_start("rst_b1");
    repeat (2) step();
    trig_start = 1'b1;
    step();
    trig_start = 1'b0;
    chk("rst_pre_fault", 32'(fault), 32'd2);
    chk("rst_pre_index", 32'(rb_index), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_flags", 32'({capture_en, trig_arm, rb_start, is_first, group_done, fault}), 32'd0);
    chk("rst_counts", 32'({rb_index, pulse_count}), 32'd0);
    step();
    rst = 1'b0;
    cmd = 16'h0000;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
